// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants for the arbitrated register bank: default sizing and
// the address-width derivation used by the top, the interface and the bench.
package reg_bank_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;

    // Address bits needed to index a bank of 'depth' entries (depth >= 2).
    function automatic int addr_w_of(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ADDR_W_DEF = addr_w_of(DEPTH_DEF);

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register bank: per-requester request/write
// controls, packed address and data slices, and the shared response.
interface reg_bank_arbiter_if
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
);
    logic                      clr_i;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        we_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]         rdata_o;

    modport master (
        output clr_i, req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  clr_i, req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Round-robin grant selection: searches upward from ptr with wrap, grants
// the first active request and reports the pointer to use after that grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   ptr_nxt
);

    logic           w_found;
    logic [PTR_W:0] w_idx;

    // Walk the requesters starting at ptr; the first active one wins and the
    // next search starts just past it. With no request the pointer holds.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found                 = 1'b1;
                gnt[w_idx[PTR_W-1:0]]   = 1'b1;
                if (w_idx == (PTR_W+1)'(NUM_REQ - 1)) begin
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = w_idx[PTR_W-1:0] + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ requesters. One access per cycle is granted
// round-robin; writes commit at the granting edge, reads return the entry as
// it stood before that edge on the following cycle. clr_i wipes the bank.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_bank_arbiter_if.slave  bus
);

    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam int PTR_W  = $clog2(NUM_REQ);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_any;
    logic               w_win_we;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_wdata;

    // Nothing may win while the bank is being cleared or held in reset.
    assign w_req = (bus.clr_i || !rst_n) ? '0 : bus.req_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .ptr_nxt (w_ptr_nxt)
    );

    assign w_any = |w_gnt;

    // Route the winning requester's controls; everyone else is ignored.
    always_comb begin
        w_win_we    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_we    = bus.we_i[i];
                w_win_addr  = bus.addr_i[i*ADDR_W +: ADDR_W];
                w_win_wdata = bus.wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Storage: async reset and sync clear both zero every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (bus.clr_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_any && w_win_we) begin
            r_mem[w_win_addr] <= w_win_wdata;
        end
    end

    // Round-robin pointer advances only on a granted cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Read response: one-cycle valid pulse to the reader; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= (w_any && !w_win_we) ? w_gnt : '0;
            if (w_any && !w_win_we) begin
                r_rdata <= r_mem[w_win_addr];
            end
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of the bank.
module tb_reg_bank_arbiter;
    import reg_bank_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic clk;
    logic rst_n;

    reg_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_bank_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    int          m_mem [D];
    int          m_ptr;
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_ptr = 0;
        e_rv  = '0;
        e_rd  = '0;
    endtask

    // Winner by the rotating-priority rule; -1 when nobody is granted.
    function automatic int model_winner(input logic [N-1:0] req, input logic clr);
        if (clr) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // One bus cycle: inputs applied at a falling edge, grant checked mid-low
    // phase, response checked at the next falling edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] we,
                        input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata,
                        input logic clr, output logic [N-1:0] gnt_seen);
        int w;
        int a;
        logic [N-1:0] eg;
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.clr_i   = clr;
        #1;
        w  = model_winner(req, clr);
        eg = (w < 0) ? '0 : (N'(1) << w);
        gnt_seen = bus.gnt_o;
        chk("gnt", 32'(bus.gnt_o), 32'(eg));
        @(posedge clk);
        e_rv = '0;
        if (clr) begin
            for (int i = 0; i < D; i++) m_mem[i] = 0;
        end else if (w >= 0) begin
            a = int'(addr[w*AW +: AW]);
            m_ptr = (w + 1) % N;
            if (we[w]) begin
                m_mem[a] = int'(wdata[w*DW +: DW]);
            end else begin
                e_rv = N'(1) << w;
                e_rd = DW'(m_mem[a]);
            end
        end
        @(negedge clk);
        chk("rvalid", 32'(bus.rvalid_o), 32'(e_rv));
        chk("rdata", 32'(bus.rdata_o), 32'(e_rd));
    endtask

    // Single-requester access helper.
    task automatic access(input int r, input logic wr, input int a, input int d,
                          output logic [N-1:0] g);
        logic [N*AW-1:0] ad;
        logic [N*DW-1:0] wd;
        ad = '0;
        wd = '0;
        ad[r*AW +: AW] = AW'(a);
        wd[r*DW +: DW] = DW'(d);
        step(N'(1) << r, wr ? (N'(1) << r) : '0, ad, wd, 1'b0, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g;
        logic [N*AW-1:0] ad;
        logic [N*DW-1:0] wd;

        rst_n       = 1'b0;
        bus.clr_i   = 1'b0;
        bus.req_i   = '1;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("rst_rdata", 32'(bus.rdata_o), 32'h0);
        rst_n = 1'b1;

        // First grant after reset goes to requester 0.
        step('1, '0, '0, '0, 1'b0, g);
        chk("first_gnt", 32'(g), 32'h1);

        // Requester 1 writes 0xA5 to entry 3, requester 2 reads it next cycle.
        access(1, 1'b1, 3, 8'hA5, g);
        access(2, 1'b0, 3, 0, g);
        chk("wr_rd_rvalid", 32'(bus.rvalid_o), 32'h4);
        chk("wr_rd_rdata", 32'(bus.rdata_o), 32'hA5);

        // Fairness: bring ptr to 0, then all four requesting for 8 cycles.
        access(3, 1'b0, 0, 0, g);
        for (int k = 0; k < 8; k++) begin
            step('1, '0, '0, '0, 1'b0, g);
            chk("fair_gnt", 32'(g), 32'(N'(1) << (k % 4)));
        end

        // Wrap: ptr = 3 after granting requester 2, then 0101 held.
        access(2, 1'b0, 1, 0, g);
        step(4'b0101, '0, '0, '0, 1'b0, g);
        chk("wrap_gnt0", 32'(g), 32'h1);
        step(4'b0101, '0, '0, '0, 1'b0, g);
        chk("wrap_gnt1", 32'(g), 32'h4);
        step(4'b0101, '0, '0, '0, 1'b0, g);
        chk("wrap_gnt2", 32'(g), 32'h1);

        // Clear: fill with 0xFF, pulse clr with a pending request, then read back.
        for (int a = 0; a < D; a++) access(0, 1'b1, a, 8'hFF, g);
        step(4'b0010, '0, '0, '0, 1'b1, g);
        chk("clr_gnt", 32'(g), 32'h0);
        step('1, '0, '0, '0, 1'b0, g);
        chk("clr_ptr_hold", 32'(g), 32'h2);
        for (int a = 0; a < D; a++) begin
            access(1, 1'b0, a, 0, g);
            chk("clr_rdata", 32'(bus.rdata_o), 32'h0);
        end

        // Back-to-back reads: requester 0 entry 5, requester 3 entry 6.
        access(1, 1'b1, 5, 8'h5C, g);
        access(2, 1'b1, 6, 8'h6D, g);
        access(0, 1'b0, 5, 0, g);
        chk("b2b_rv0", 32'(bus.rvalid_o), 32'h1);
        chk("b2b_rd0", 32'(bus.rdata_o), 32'h5C);
        access(3, 1'b0, 6, 0, g);
        chk("b2b_rv1", 32'(bus.rvalid_o), 32'h8);
        chk("b2b_rd1", 32'(bus.rdata_o), 32'h6D);

        // Random traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            ad = N*AW'($urandom);
            wd = {$urandom, $urandom};
            step(N'($urandom), N'($urandom), ad, wd, ($urandom_range(0, 15) == 0), g);
        end

        // Reset in the middle of a read.
        access(1, 1'b1, 2, 8'h3C, g);
        ad = '0;
        ad[1*AW +: AW] = 3'd2;
        bus.req_i  = 4'b0010;
        bus.we_i   = '0;
        bus.addr_i = ad;
        bus.clr_i  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("midrst_rdata", 32'(bus.rdata_o), 32'h0);
        chk("midrst_gnt", 32'(bus.gnt_o), 32'h0);
        @(negedge clk);
        chk("midrst_rvalid_hold", 32'(bus.rvalid_o), 32'h0);
        rst_n = 1'b1;
        step('1, '0, '0, '0, 1'b0, g);
        chk("midrst_first_gnt", 32'(g), 32'h1);
        for (int a = 0; a < D; a++) begin
            access(a % N, 1'b0, a, 0, g);
            chk("post_rst_rdata", 32'(bus.rdata_o), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, the width of a register entry.
REQ-003 SHALL have parameter DEPTH, default 8, the number of register entries (power of 2); ADDR_W = log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port clr_i  input  1  synchronous clear of all entries.
REQ-007 SHALL have port req_i  input  NUM_REQ  per-requester access request.
REQ-008 SHALL have port we_i  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-009 SHALL have port addr_i  input  NUM_REQ*ADDR_W  per-requester entry address; requester i occupies slice i.
REQ-010 SHALL have port wdata_i  input  NUM_REQ*DATA_W  per-requester write data; requester i occupies slice i.
REQ-011 SHALL have port gnt_o  output  NUM_REQ  one-hot grant, combinational, valid in the cycle the access is performed.
REQ-012 SHALL have port rvalid_o  output  NUM_REQ  one-hot read-data valid, registered.
REQ-013 SHALL have port rdata_o  output  DATA_W  read data for the requester flagged by rvalid_o.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt_o is 0 when req_i is 0 or clr_i is 1.
REQ-015 SHALL arbitrate round-robin: search starts at index ptr, ascending with wrap from NUM_REQ-1 to 0; the first set req_i bit wins.
REQ-016 SHALL set ptr to (winner+1) mod NUM_REQ at the clock edge of a granted cycle; ptr SHALL hold when there is no grant.
REQ-017 SHALL, on a granted write, update entry addr_i[winner] with wdata_i[winner] at that clock edge.
REQ-018 SHALL, on a granted read, present the entry contents sampled at that edge on rdata_o and set rvalid_o[winner] for exactly the next cycle (latency 1).
REQ-019 SHALL return the pre-write value when a read in cycle N follows a write to the same entry in cycle N-1 only if the write was not yet committed; because the write commits at the edge ending cycle N-1, the read returns the new value.
REQ-020 SHALL keep a requester's request pending while req_i stays high; the requester drops req_i after seeing gnt_o; no request queuing inside the block.
REQ-021 SHALL, when clr_i is 1, zero all entries at that edge, grant nothing, leave ptr unchanged, and deassert rvalid_o in the next cycle.
REQ-022 SHALL hold rdata_o at its last value and rvalid_o at 0 in cycles with no read completing.
REQ-023 SHALL ignore we_i, addr_i and wdata_i of requesters that are not granted.

Reset
REQ-024 SHALL, while rst_n is 0, asynchronously force all entries to 0, ptr to 0, rvalid_o to 0 and rdata_o to 0.
REQ-025 SHALL drop any in-flight read (rvalid_o = 0) when rst_n asserts mid-operation; gnt_o is 0 while rst_n is 0.
REQ-026 SHALL begin arbitrating on the first rising edge after rst_n deasserts, with ptr = 0.

Structure
REQ-027 SHALL place default NUM_REQ, DATA_W and DEPTH constants, and the ADDR_W derivation, in shared package reg_bank_pkg.
REQ-028 SHALL implement grant selection and pointer update in one sub-module, rr_arbiter (inputs req, ptr; output one-hot gnt), instantiated once.
REQ-029 SHALL implement storage as a flat array of DATA_W-bit registers inside reg_bank_arbiter; there are no other sub-modules.

Verification
REQ-030 SHALL verify reset: rst_n low mid-read, then read entries 0..7 -> all 0, rvalid_o low during reset, first grant goes to requester 0.
REQ-031 SHALL verify write/read: requester 1 writes 0xA5 to entry 3, next cycle requester 2 reads entry 3 -> rvalid_o = 4'b0100 and rdata_o = 0xA5 one cycle later.
REQ-032 SHALL verify fairness: req_i = 4'b1111 held for 8 cycles from ptr = 0 -> grants 0,1,2,3,0,1,2,3.
REQ-033 SHALL verify wrap: ptr = 3, req_i = 4'b0101 -> grant 0, then grant 2, then grant 0.
REQ-034 SHALL verify clear: entries loaded with 0xFF, clr_i pulsed with req_i = 4'b0010 -> gnt_o = 0 that cycle, ptr unchanged, all subsequent reads return 0x00.
REQ-035 SHALL verify back-to-back reads from requesters 0 and 3 to entries 5 and 6 -> rvalid_o sequence 0001 then 1000 with the matching data each cycle.
